// File: rtl/lsu_ctrl.sv
// Load/store control stage in front of the physical-memory block.
// Takes one request at a time, holds the memory enables for MEM_LATENCY
// cycles on an 8-byte-aligned address, and returns lane-shifted,
// sign/zero-extended load data (or a store acknowledge) on a response channel.
// Optional build macro LSU_ALIGN_CHECK_EN: when defined, misaligned requests
// are answered with resp_err=1 and never touch memory; when undefined, the
// low address bits are used as-is and out-of-word lanes are dropped.
module lsu_ctrl #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] mem_raddr,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  output logic        mem_read_en,
  output logic        mem_write_en,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  count;
  logic        op_wen;
  logic [63:0] op_addr;
  logic [63:0] op_wdata;
  logic [1:0]  op_size;
  logic        op_unsigned;
  logic        misaligned;
  logic [7:0]  byte_en;

  // Shift the addressed lanes down to bit 0, then sign- or zero-extend.
  function automatic logic [63:0] extract(input logic [63:0] raw,
                                          input logic [2:0]  off,
                                          input logic [1:0]  size,
                                          input logic        uns);
    logic [63:0] s;
    s = raw >> {off, 3'b000};
    case (size)
      2'd0:    extract = uns ? {56'd0, s[7:0]}  : {{56{s[7]}},  s[7:0]};
      2'd1:    extract = uns ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
      2'd2:    extract = uns ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
      default: extract = s;
    endcase
  endfunction

`ifdef LSU_ALIGN_CHECK_EN
  // Natural alignment check on the incoming request.
  always_comb begin
    case (req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  // Unshifted byte mask for the registered access size.
  always_comb begin
    case (op_size)
      2'd0:    byte_en = 8'h01;
      2'd1:    byte_en = 8'h03;
      2'd2:    byte_en = 8'h0F;
      default: byte_en = 8'hFF;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and all handshake/memory outputs.
  // NOTE: every output gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    mem_raddr    = '0;
    mem_waddr    = '0;
    mem_wdata    = '0;
    mem_wmask    = '0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = misaligned ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_raddr    = {op_addr[63:3], 3'b000};
        mem_waddr    = {op_addr[63:3], 3'b000};
        mem_wmask    = byte_en << op_addr[2:0];
        mem_wdata    = op_wdata << {op_addr[2:0], 3'b000};
        mem_read_en  = ~op_wen;
        mem_write_en = op_wen;
        if (count == 4'd0) state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, latency counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      op_wen      <= 1'b0;
      op_addr     <= '0;
      op_wdata    <= '0;
      op_size     <= '0;
      op_unsigned <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_wen      <= req_wen;
            op_addr     <= req_addr;
            op_wdata    <= req_wdata;
            op_size     <= req_size;
            op_unsigned <= req_unsigned;
            resp_rdata  <= '0;
            resp_err    <= misaligned;
            count       <= 4'(MEM_LATENCY - 1);
          end
        end
        ACCESS: begin
          if (count != 4'd0) count <= count - 4'd1;
          else if (!op_wen)
            resp_rdata <= extract(mem_rdata, op_addr[2:0], op_size, op_unsigned);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl, built with MEM_LATENCY=3. Inputs change and
// outputs are sampled on the falling edge, away from the active rising edge.
module tb_lsu_ctrl;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic [63:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        mem_read_en, mem_write_en;

  int vectors = 0;
  int miscompares = 0;

  // Observations gathered by do_req.
  int          rd_cycles, wr_cycles;
  logic [63:0] seen_raddr, seen_waddr, seen_wdata;
  logic [7:0]  seen_wmask;
  logic [63:0] held_rdata;

  always #5 clk = ~clk;

  lsu_ctrl #(.MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, then wait (bounded) for the response, recording the
  // memory-side activity seen on the way.
  task automatic do_req(input logic wen, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [1:0] size,
                        input logic uns);
    int waited;
    rd_cycles = 0; wr_cycles = 0;
    seen_raddr = '0; seen_waddr = '0; seen_wdata = '0; seen_wmask = '0;
    @(negedge clk);
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_wen = wen; req_addr = addr;
    req_wdata = wdata; req_size = size; req_unsigned = uns;
    @(negedge clk);
    req_valid = 1'b0;
    waited = 0;
    while (!resp_valid && waited < 40) begin
      if (mem_read_en)  begin rd_cycles++; seen_raddr = mem_raddr; end
      if (mem_write_en) begin
        wr_cycles++; seen_waddr = mem_waddr;
        seen_wdata = mem_wdata; seen_wmask = mem_wmask;
      end
      waited++;
      @(negedge clk);
    end
    check("resp_timeout", 64'(resp_valid), 64'd1);
  endtask

  task automatic release_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_valid_after_accept", 64'(resp_valid), 64'd0);
    check("req_ready_after_accept", 64'(req_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0;
    req_wdata = '0; req_size = '0; req_unsigned = 1'b0;
    resp_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_enables", {62'd0, mem_read_en, mem_write_en}, 64'd0);
    check("rst_raddr", mem_raddr, 64'd0);
    check("rst_wmask", 64'(mem_wmask), 64'd0);
    rst = 1'b0;

    // Signed byte load: byte 3 = 0x80.
    mem_rdata = 64'h00000000_80FF0000;
    do_req(1'b0, 64'h80000003, 64'd0, 2'd0, 1'b0);
    check("lb_rdata", resp_rdata, 64'hFFFFFFFF_FFFFFF80);
    check("lb_raddr", seen_raddr, 64'h80000000);
    check("lb_rd_cycles", 64'(rd_cycles), 64'(LAT));
    check("lb_wr_cycles", 64'(wr_cycles), 64'd0);
    check("lb_err", 64'(resp_err), 64'd0);
    check("lb_req_ready_resp", 64'(req_ready), 64'd0);
    release_resp();

    // Unsigned and signed word loads from the upper half.
    mem_rdata = 64'h89ABCDEF_01234567;
    do_req(1'b0, 64'h80000004, 64'd0, 2'd2, 1'b1);
    check("lwu_rdata", resp_rdata, 64'h00000000_89ABCDEF);
    release_resp();
    do_req(1'b0, 64'h80000004, 64'd0, 2'd2, 1'b0);
    check("lw_rdata", resp_rdata, 64'hFFFFFFFF_89ABCDEF);
    release_resp();

    // Signed half from the top lane, then an aligned double passthrough.
    do_req(1'b0, 64'h80000006, 64'd0, 2'd1, 1'b0);
    check("lh_rdata", resp_rdata, 64'hFFFFFFFF_FFFF89AB);
    release_resp();
    do_req(1'b0, 64'h80000008, 64'd0, 2'd3, 1'b0);
    check("ld_rdata", resp_rdata, 64'h89ABCDEF_01234567);
    check("ld_raddr", seen_raddr, 64'h80000008);
    release_resp();

    // Half store into the top lane.
    do_req(1'b1, 64'h80000006, 64'h1234, 2'd1, 1'b0);
    check("sh_waddr", seen_waddr, 64'h80000000);
    check("sh_wmask", 64'(seen_wmask), 64'hC0);
    check("sh_wdata", seen_wdata, 64'h1234_0000_0000_0000);
    check("sh_wr_cycles", 64'(wr_cycles), 64'(LAT));
    check("sh_rd_cycles", 64'(rd_cycles), 64'd0);
    check("sh_rdata", resp_rdata, 64'd0);
    check("sh_err", 64'(resp_err), 64'd0);
    release_resp();

    // Misaligned word load and word store.
`ifdef LSU_ALIGN_CHECK_EN
    do_req(1'b0, 64'h80000002, 64'd0, 2'd2, 1'b0);
    check("mis_ld_err", 64'(resp_err), 64'd1);
    check("mis_ld_rdata", resp_rdata, 64'd0);
    check("mis_ld_enables", 64'(rd_cycles + wr_cycles), 64'd0);
    release_resp();
    do_req(1'b1, 64'h80000006, 64'hAABBCCDD, 2'd2, 1'b0);
    check("mis_st_err", 64'(resp_err), 64'd1);
    check("mis_st_enables", 64'(rd_cycles + wr_cycles), 64'd0);
    release_resp();
`else
    do_req(1'b0, 64'h80000002, 64'd0, 2'd2, 1'b0);
    check("mis_ld_err", 64'(resp_err), 64'd0);
    check("mis_ld_rdata", resp_rdata, 64'hFFFFFFFF_CDEF0123);
    check("mis_ld_rd_cycles", 64'(rd_cycles), 64'(LAT));
    release_resp();
    do_req(1'b1, 64'h80000006, 64'hAABBCCDD, 2'd2, 1'b0);
    check("mis_st_err", 64'(resp_err), 64'd0);
    check("mis_st_wmask", 64'(seen_wmask), 64'hC0);
    check("mis_st_wdata", seen_wdata, 64'hCCDD_0000_0000_0000);
    release_resp();
`endif

    // Backpressure: hold resp_ready low with a new request waiting.
    mem_rdata = 64'h00000000_0000007F;
    do_req(1'b0, 64'h80000010, 64'd0, 2'd0, 1'b0);
    held_rdata = 64'h7F;
    req_valid = 1'b1; req_addr = 64'h80000020; req_size = 2'd3; req_wen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_resp_valid", 64'(resp_valid), 64'd1);
      check("bp_rdata", resp_rdata, held_rdata);
      check("bp_req_ready", 64'(req_ready), 64'd0);
      check("bp_enables", {62'd0, mem_read_en, mem_write_en}, 64'd0);
    end
    req_valid = 1'b0;
    release_resp();
    // Next request is accepted on the following edge.
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_next_read_en", 64'(mem_read_en), 64'd1);
    check("bp_next_raddr", mem_raddr, 64'h80000020);
    repeat (LAT) @(negedge clk);
    check("bp_next_resp", 64'(resp_valid), 64'd1);
    release_resp();

    // Reset while in ACCESS.
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h80000000;
    req_size = 2'd3; req_wdata = 64'h1;
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_write_en", 64'(mem_write_en), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_enables", {62'd0, mem_read_en, mem_write_en}, 64'd0);
    check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    check("mid_rst_req_ready", 64'(req_ready), 64'd1);
    check("mid_rst_wmask", 64'(mem_wmask), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
